fifo_pop_ctrl: RTL and testbench
================================

// Module: fifo_pop_ctrl
// PURPOSE
//  Downstream consumer of the data FIFO. Pops words when the FIFO is non-empty and the sink accepts them.
//  Presents each popped word on a valid/ready output register.
//  Tracks FIFO occupancy, drives a hysteresis pause back to the upstream writer, and latches FIFO errors.
//  Sits between the FIFO outputs and the next stage (arbiter/demux).
// PARAMETERS
//  DATA_BITS  10  FIFO word width
//  ADDR_BITS  3   FIFO address width; DEPTH = 2**ADDR_BITS
//  CNT_BITS   8   width of delivered-word counter
// PORTS
//  clk              in   1            single clock, all logic on posedge
//  reset            in   1            synchronous, active-high
//  fifo_write_in    in   1            copy of upstream FIFO write strobe (occupancy tracking)
//  fifo_full_in     in   1            FIFO full flag
//  fifo_empty_in    in   1            FIFO empty flag
//  error_fifo_in    in   1            FIFO error flag (write-when-full / read-when-empty)
//  fifo_data_in     in   DATA_BITS    FIFO data_out; valid 1 cycle after fifo_read
//  high_limit       in   ADDR_BITS    pause set threshold
//  low_limit        in   ADDR_BITS    pause clear threshold
//  ready_in         in   1            sink accepts data_out this cycle
//  fifo_read        out  1            FIFO pop strobe
//  data_out         out  DATA_BITS    registered popped word
//  valid_out        out  1            data_out holds an unconsumed word
//  pause            out  1            upstream must stop writing
//  occupancy        out  ADDR_BITS+1  tracked FIFO fill level, 0..DEPTH
//  error_out        out  1            sticky error
//  words_sent       out  CNT_BITS     count of accepted transfers (valid_out & ready_in)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; in-flight FIFO data discarded. Reset has priority in every state, including mid-WAIT.
//  FSM (registered state):
//   IDLE: fifo_read = !fifo_empty_in & !error_out.
//         If asserted -> WAIT.
//   WAIT: capture fifo_data_in into data_out; valid_out=1 next cycle -> HOLD.
//   HOLD: valid_out=1, data_out stable.
//         ready_in=1: transfer done, words_sent+1.
//           Same cycle fifo_read = !fifo_empty_in & !error_out; -> WAIT if read, else -> IDLE.
//           valid_out=0 next cycle.
//         ready_in=0: stay in HOLD, fifo_read=0.
//  Latency: fifo_read at t -> data captured at edge t+1 -> valid_out high from t+2.
//  Max throughput: one word per 2 cycles.
//  fifo_read is combinational from state and registered/input flags; never asserted while fifo_empty_in=1.
//  Occupancy:
//   +1 on fifo_write_in & !fifo_full_in; -1 on fifo_read & !fifo_empty_in.
//   Both in the same cycle -> unchanged.
//   Saturates at 0 and DEPTH (no wrap).
//  Pause (registered, hysteresis):
//   Set when next occupancy >= high_limit.
//   Clear when next occupancy <= low_limit.
//   Otherwise hold.
//   If low_limit >= high_limit: pause = (next occupancy >= high_limit), no hysteresis.
//  Error: error_out set on any cycle error_fifo_in=1; sticky until reset.
//   While error_out=1, no new fifo_read. A word already in WAIT/HOLD still completes its handshake.
//  words_sent wraps modulo 2**CNT_BITS.
// STRUCTURE
//  Shared include fifo_defs.vh: FSM state encodings (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2) and the default DATA_BITS/ADDR_BITS.
//  Sub-module fifo_occ_tracker: occupancy counter plus pause hysteresis.
//   Inputs: push, pop, full, empty, limits. Outputs: occupancy, pause.
//  Top module holds the FSM, output register, error latch and words_sent.
// TESTING (HIGH=6, LOW=2, DEPTH=8)
//  1. reset=1 for 3 cycles with random inputs -> all outputs 0, fifo_read=0.
//  2. Push 0x155 once, ready_in=1 -> fifo_read 1 cycle after empty drops.
//     valid_out=1, data_out=0x155 two cycles after fifo_read; words_sent=1; occupancy back to 0.
//  3. ready_in=0, push 7 words -> pause=1 when occupancy reaches 6.
//     Then ready_in=1 -> pause stays 1 at occupancy 5..3, clears when occupancy=2.
//  4. valid_out=1, ready_in=0 for 5 cycles -> data_out stable, fifo_read=0.
//     Raise ready_in -> words_sent+1 and next fifo_read in the same cycle.
//  5. Pulse error_fifo_in 1 cycle with FIFO non-empty -> error_out=1 held; no further fifo_read.
//     Reset -> error_out=0, reads resume.
//  6. Assert reset the cycle after fifo_read (WAIT) -> valid_out stays 0, occupancy=0, state IDLE.

Source files
------------

// File: rtl/fifo_pop_ctrl_pkg.sv
// fifo_pop_ctrl_pkg
//   Shared definitions for the FIFO pop controller: default widths and the
//   pop FSM state encoding (IDLE=0, WAIT=1, HOLD=2).
package fifo_pop_ctrl_pkg;

    localparam int unsigned DEF_DATA_BITS = 10;
    localparam int unsigned DEF_ADDR_BITS = 3;
    localparam int unsigned DEF_CNT_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no word in flight
        ST_WAIT = 2'd1,  // pop issued, FIFO data arrives this cycle
        ST_HOLD = 2'd2   // word presented on data_out, waiting for ready_in
    } pop_state_e;

endpackage

// File: rtl/fifo_pop_ctrl_occ_tracker.sv
// fifo_occ_tracker
//   Tracks FIFO fill level from the push/pop strobes and drives a registered
//   hysteresis pause back to the upstream writer.
// Ports
//   clk, reset              clock, synchronous active-high reset
//   push, pop               write / read strobes seen by the FIFO
//   full, empty             FIFO flags; qualify push and pop
//   high_limit, low_limit   pause set / clear thresholds
//   occupancy               tracked fill level, 0..DEPTH, saturating
//   pause                   upstream must stop writing
module fifo_occ_tracker
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 full,
    input  logic                 empty,
    input  logic [ADDR_BITS-1:0] high_limit,
    input  logic [ADDR_BITS-1:0] low_limit,
    output logic [ADDR_BITS:0]   occupancy,
    output logic                 pause
);

    localparam logic [ADDR_BITS:0] DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] OCC_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [ADDR_BITS:0] occ_q, occ_d;
    logic               pause_q, pause_d;
    logic               inc, dec;
    logic [ADDR_BITS:0] hi_ext, lo_ext;

    assign inc    = push && !full;
    assign dec    = pop && !empty;
    assign hi_ext = {1'b0, high_limit};
    assign lo_ext = {1'b0, low_limit};

    always_comb begin
        occ_d   = occ_q;
        pause_d = pause_q;
        if (inc && !dec && occ_q != DEPTH) begin
            occ_d = occ_q + OCC_ONE;
        end else if (dec && !inc && occ_q != '0) begin
            occ_d = occ_q - OCC_ONE;
        end
        // Degenerate thresholds collapse to a plain compare; otherwise the
        // band between the limits holds the previous pause value.
        if (low_limit >= high_limit) begin
            pause_d = (occ_d >= hi_ext);
        end else if (occ_d >= hi_ext) begin
            pause_d = 1'b1;
        end else if (occ_d <= lo_ext) begin
            pause_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= '0;
            pause_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            pause_q <= pause_d;
        end
    end

    assign occupancy = occ_q;
    assign pause     = pause_q;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl
//   Pops words from the data FIFO and presents each one on a valid/ready
//   output register; tracks occupancy, drives upstream pause, latches errors
//   and counts delivered words.
// Ports
//   clk, reset           clock, synchronous active-high reset
//   fifo_write_in        upstream FIFO write strobe (occupancy tracking)
//   fifo_full_in/_empty_in/error_fifo_in   FIFO status flags
//   fifo_data_in         FIFO read data, valid one cycle after fifo_read
//   high_limit/low_limit pause hysteresis thresholds
//   ready_in             sink accepts data_out this cycle
//   fifo_read            FIFO pop strobe (combinational)
//   data_out/valid_out   registered popped word and its valid flag
//   pause, occupancy     upstream back-pressure and tracked fill level
//   error_out            sticky FIFO error
//   words_sent           accepted transfers, wrapping
module fifo_pop_ctrl
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned CNT_BITS  = DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_write_in,
    input  logic                 fifo_full_in,
    input  logic                 fifo_empty_in,
    input  logic                 error_fifo_in,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic [ADDR_BITS-1:0] high_limit,
    input  logic [ADDR_BITS-1:0] low_limit,
    input  logic                 ready_in,
    output logic                 fifo_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 pause,
    output logic [ADDR_BITS:0]   occupancy,
    output logic                 error_out,
    output logic [CNT_BITS-1:0]  words_sent
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    pop_state_e           state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic [CNT_BITS-1:0]  sent_q, sent_d;
    logic                 read_ok;
    logic                 rd;

    // Reset masks the pop so the FIFO never loses a word to a controller
    // whose state is being cleared.
    assign read_ok = !fifo_empty_in && !error_q && !reset;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        sent_d  = sent_q;
        error_d = error_q | error_fifo_in;
        rd      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_ok) begin
                    rd      = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                data_d  = fifo_data_in;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (ready_in) begin
                    sent_d  = sent_q + CNT_ONE;
                    valid_d = 1'b0;
                    if (read_ok) begin
                        rd      = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
            sent_q  <= sent_d;
        end
    end

    fifo_occ_tracker #(
        .ADDR_BITS(ADDR_BITS)
    ) u_occ (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_write_in),
        .pop       (rd),
        .full      (fifo_full_in),
        .empty     (fifo_empty_in),
        .high_limit(high_limit),
        .low_limit (low_limit),
        .occupancy (occupancy),
        .pause     (pause)
    );

    assign fifo_read  = rd;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign error_out  = error_q;
    assign words_sent = sent_q;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
module tb_fifo_pop_ctrl;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, fifo_write_in, fifo_full_in, fifo_empty_in;
    logic          error_fifo_in, ready_in;
    logic [DW-1:0] fifo_data_in;
    logic [AW-1:0] high_limit, low_limit;
    logic          fifo_read, valid_out, pause, error_out;
    logic [DW-1:0] data_out;
    logic [AW:0]   occupancy;
    logic [CW-1:0] words_sent;

    fifo_pop_ctrl #(
        .DATA_BITS(DW),
        .ADDR_BITS(AW),
        .CNT_BITS (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_write_in(fifo_write_in),
        .fifo_full_in (fifo_full_in),
        .fifo_empty_in(fifo_empty_in),
        .error_fifo_in(error_fifo_in),
        .fifo_data_in (fifo_data_in),
        .high_limit   (high_limit),
        .low_limit    (low_limit),
        .ready_in     (ready_in),
        .fifo_read    (fifo_read),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .pause        (pause),
        .occupancy    (occupancy),
        .error_out    (error_out),
        .words_sent   (words_sent)
    );

    // Behavioural FIFO plus expected-delivery scoreboard
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rp, wp;
    int            cnt;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_q [$];
    int            sent_model;
    bit            pmodel;

    int checks, errors, cyc;
    bit chk_en;

    // Snapshot of DUT outputs taken mid-cycle by cycle()
    logic          s_read, s_valid, s_pause, s_err, s_empty;
    logic [DW-1:0] s_data;
    logic [AW:0]   s_occ;
    logic [CW-1:0] s_sent;
    int            s_cyc;

    task automatic cycle();
        bit rd, wr, rst, acc, winc, rdec;
        @(negedge clk);
        s_read = fifo_read; s_valid = valid_out; s_pause = pause; s_err = error_out;
        s_empty = fifo_empty_in; s_data = data_out; s_occ = occupancy; s_sent = words_sent;
        s_cyc = cyc;
        rd  = fifo_read;
        wr  = fifo_write_in;
        rst = reset;
        acc = valid_out && ready_in && !reset;
        if (chk_en) begin
            checks++;
            if (rd && fifo_empty_in) begin
                errors++; $display("FAIL read_when_empty: fifo_read=%0b empty=%0b required read=0", rd, fifo_empty_in);
            end
            checks++;
            if (occupancy !== (AW+1)'(cnt)) begin
                errors++; $display("FAIL occupancy: got %0d required %0d (cycle %0d)", occupancy, cnt, cyc);
            end
            checks++;
            if (pause !== pmodel) begin
                errors++; $display("FAIL pause: got %0b required %0b (occ %0d cycle %0d)", pause, pmodel, cnt, cyc);
            end
            checks++;
            if (words_sent !== CW'(sent_model)) begin
                errors++; $display("FAIL words_sent: got %0d required %0d", words_sent, CW'(sent_model));
            end
            if (acc) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL data_out: got %0h with no word expected", data_out);
                end else if (data_out !== exp_q[0]) begin
                    errors++; $display("FAIL data_out: got %0h required %0h", data_out, exp_q[0]);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                sent_model++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            cnt = 0; rp = '0; wp = '0; exp_q.delete(); sent_model = 0; pmodel = 0;
        end else begin
            winc = wr && (cnt < DEPTH);
            rdec = rd && (cnt > 0);
            if (rdec) begin
                fifo_data_in = mem[rp];
                rp = rp + AW'(1);
            end
            if (winc) begin
                mem[wp] = wdata;
                wp = wp + AW'(1);
                exp_q.push_back(wdata);
            end
            cnt = cnt + int'(winc) - int'(rdec);
            if (int'(low_limit) >= int'(high_limit)) pmodel = (cnt >= int'(high_limit));
            else if (cnt >= int'(high_limit)) pmodel = 1'b1;
            else if (cnt <= int'(low_limit)) pmodel = 1'b0;
        end
        fifo_empty_in = (cnt == 0);
        fifo_full_in  = (cnt == DEPTH);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wdata = w; fifo_write_in = 1'b1;
        cycle();
        fifo_write_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fifo_write_in = 1'($urandom); error_fifo_in = 1'($urandom);
            ready_in = 1'($urandom); wdata = DW'($urandom);
            high_limit = AW'($urandom); low_limit = AW'($urandom);
            cycle();
            checks++;
            if (s_read !== 1'b0 || s_valid !== 1'b0 || s_data !== '0 || s_occ !== '0 ||
                s_pause !== 1'b0 || s_err !== 1'b0 || s_sent !== '0) begin
                errors++;
                $display("FAIL reset_outputs: read=%0b valid=%0b data=%0h occ=%0d pause=%0b err=%0b sent=%0d required all 0",
                         s_read, s_valid, s_data, s_occ, s_pause, s_err, s_sent);
            end
        end
        reset = 1'b0; fifo_write_in = 1'b0; error_fifo_in = 1'b0; ready_in = 1'b0;
        high_limit = 3'd6; low_limit = 3'd2;
        chk_en = 1'b1;
        cycle();
    endtask

    task automatic test_single_word();
        int  rcyc;
        bit  seen;
        ready_in = 1'b1;
        push_word(10'h155);
        cycle();
        checks++;
        if (s_empty !== 1'b0 || s_read !== 1'b1) begin
            errors++; $display("FAIL first_read: empty=%0b read=%0b required empty=0 read=1", s_empty, s_read);
        end
        rcyc = s_cyc;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle();
            seen = s_valid;
        end
        checks++;
        if (!seen || (s_cyc - rcyc) != 2 || s_data !== 10'h155) begin
            errors++; $display("FAIL read_latency: valid=%0b delay=%0d data=%0h required 1/2/155", seen, s_cyc - rcyc, s_data);
        end
        cycle();
        checks++;
        if (s_sent !== 8'd1 || s_occ !== '0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: sent=%0d occ=%0d valid=%0b required 1/0/0", s_sent, s_occ, s_valid);
        end
    endtask

    task automatic test_pause_hysteresis();
        bit seen2, drained;
        ready_in = 1'b0;
        for (int i = 0; i < 7; i++) push_word(DW'($urandom));
        cycle();
        checks++;
        if (s_occ !== 4'd6 || s_pause !== 1'b1) begin
            errors++; $display("FAIL pause_set: occ=%0d pause=%0b required 6/1", s_occ, s_pause);
        end
        ready_in = 1'b1;
        seen2 = 0; drained = 0;
        for (int i = 0; i < 40 && !drained; i++) begin
            cycle();
            checks++;
            if (s_pause !== (int'(s_occ) >= 3)) begin
                errors++; $display("FAIL pause_drain: occ=%0d pause=%0b required %0b", s_occ, s_pause, int'(s_occ) >= 3);
            end
            if (s_occ == 4'd2) seen2 = 1;
            drained = (s_occ == '0) && !s_valid;
        end
        checks++;
        if (!drained || !seen2) begin
            errors++; $display("FAIL drain: drained=%0b saw_occ2=%0b required 1/1", drained, seen2);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        logic [CW-1:0] prev;
        bit            seen;
        ready_in = 1'b0;
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle();
            seen = s_valid;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL hold_valid: valid=%0b required 1", s_valid);
        end
        held = s_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (s_valid !== 1'b1 || s_data !== held || s_read !== 1'b0) begin
                errors++; $display("FAIL hold_stable: valid=%0b data=%0h read=%0b required 1/%0h/0", s_valid, s_data, s_read, held);
            end
        end
        prev = s_sent;
        ready_in = 1'b1;
        cycle();
        checks++;
        if (s_read !== 1'b1 || s_valid !== 1'b1) begin
            errors++; $display("FAIL read_on_accept: read=%0b valid=%0b required 1/1", s_read, s_valid);
        end
        cycle();
        checks++;
        if (s_sent !== prev + CW'(1)) begin
            errors++; $display("FAIL sent_inc: got %0d required %0d", s_sent, prev + CW'(1));
        end
        for (int i = 0; i < 6; i++) cycle();
    endtask

    task automatic test_error_latch();
        logic [CW-1:0] sent0;
        bit            seen;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle();
            seen = s_valid;
        end
        error_fifo_in = 1'b1;
        cycle();
        error_fifo_in = 1'b0;
        cycle();
        checks++;
        if (!seen || s_err !== 1'b1) begin
            errors++; $display("FAIL error_set: valid_seen=%0b err=%0b required 1/1", seen, s_err);
        end
        sent0 = s_sent;
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (s_read !== 1'b0 || s_err !== 1'b1) begin
                errors++; $display("FAIL error_blocks_read: read=%0b err=%0b required 0/1", s_read, s_err);
            end
        end
        checks++;
        if (s_sent !== sent0 + CW'(1) || s_valid !== 1'b0) begin
            errors++; $display("FAIL error_inflight: sent=%0d valid=%0b required %0d/0", s_sent, s_valid, sent0 + CW'(1));
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        checks++;
        if (s_err !== 1'b0) begin
            errors++; $display("FAIL error_clear: err=%0b required 0", s_err);
        end
        push_word(DW'($urandom));
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            cycle();
            seen = s_read;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reads_resume: read=%0b required 1", seen);
        end
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        ready_in = 1'b1;
        push_word(DW'($urandom));
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            cycle();
            seen = s_read;
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (!seen || s_valid !== 1'b0 || s_occ !== '0 || s_read !== 1'b0) begin
                errors++; $display("FAIL reset_in_wait: read_seen=%0b valid=%0b occ=%0d read=%0b required 1/0/0/0",
                                   seen, s_valid, s_occ, s_read);
            end
        end
        push_word(DW'($urandom));
        cycle();
        checks++;
        if (s_read !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset: read=%0b required 1", s_read);
        end
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                high_limit = AW'($urandom);
                low_limit  = AW'($urandom);
            end
            fifo_write_in = 1'($urandom);
            wdata         = DW'($urandom);
            ready_in      = ($urandom_range(3) != 0);
            cycle();
        end
        fifo_write_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 24; i++) cycle();
        checks++;
        if (exp_q.size() != 0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL random_drain: pending=%0d valid=%0b required 0/0", exp_q.size(), s_valid);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; chk_en = 0;
        cnt = 0; rp = '0; wp = '0; sent_model = 0; pmodel = 0;
        reset = 1'b1; fifo_write_in = 1'b0; error_fifo_in = 1'b0; ready_in = 1'b0;
        wdata = '0; fifo_data_in = '0; fifo_empty_in = 1'b1; fifo_full_in = 1'b0;
        high_limit = 3'd6; low_limit = 3'd2;
        test_reset();
        test_single_word();
        test_pause_hysteresis();
        test_backpressure();
        test_error_latch();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
